// File: rtl/key_repeat_conditioner.sv
// Conditions the APF controller key word into held/pressed/released vectors plus an auto-repeat pulse vector.
// Optional per-bit debounce is enabled by defining KEY_DEBOUNCE_EN.
module key_repeat_conditioner #(
    parameter int unsigned REPEAT_DELAY   = 20,
    parameter int unsigned REPEAT_RATE    = 4,
    parameter int unsigned DEBOUNCE_TICKS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [31:0] key_in,
    output logic [15:0] held,
    output logic [15:0] pressed,
    output logic [15:0] released,
    output logic [15:0] repeat_out,
    output logic        connected,
    output logic [3:0]  ctype
);

    localparam int unsigned NKEYS   = 16;
    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [3:0]  CTYPE_NONE = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } state_t;

    logic [NKEYS-1:0] key_q, key_d;
    logic [3:0]       ctype_q, ctype_d;
    logic             connected_q, connected_d;
    logic [NKEYS-1:0] raw;
    logic [NKEYS-1:0] held_q, held_d;
    logic [NKEYS-1:0] pressed_q, pressed_d;
    logic [NKEYS-1:0] released_q, released_d;
    logic [NKEYS-1:0] repeat_q, repeat_d;
    logic             change;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             unused_bits_c;

    // Controller bits [27:16] carry no button information.
    assign unused_bits_c = ^key_in[27:16];

    always_comb begin
        key_d       = key_in[NKEYS-1:0];
        ctype_d     = key_in[31:28];
        connected_d = (key_in[31:28] != CTYPE_NONE);
    end

    assign raw = key_q & {NKEYS{connected_q}};

`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);

    logic [DW-1:0] dbc_q [NKEYS];
    logic [DW-1:0] dbc_d [NKEYS];

    // A bit follows raw only after disagreeing for DEBOUNCE_TICKS ticks; disconnect bypasses this.
    always_comb begin
        held_d = held_q;
        for (int i = 0; i < int'(NKEYS); i++) begin
            dbc_d[i] = dbc_q[i];
        end
        if (!connected_q) begin
            held_d = '0;
            for (int i = 0; i < int'(NKEYS); i++) begin
                dbc_d[i] = '0;
            end
        end else begin
            for (int i = 0; i < int'(NKEYS); i++) begin
                if (raw[i] == held_q[i]) begin
                    dbc_d[i] = '0;
                end else if (tick) begin
                    if (dbc_q[i] == DW'(DEBOUNCE_TICKS - 1)) begin
                        held_d[i] = raw[i];
                        dbc_d[i]  = '0;
                    end else begin
                        dbc_d[i] = dbc_q[i] + DW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NKEYS); i++) begin
                dbc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NKEYS); i++) begin
                dbc_q[i] <= dbc_d[i];
            end
        end
    end
`else
    localparam int unsigned unused_debounce_ticks = DEBOUNCE_TICKS;

    always_comb begin
        held_d = raw;
    end
`endif

    assign pressed_d  = held_d & ~held_q;
    assign released_d = ~held_d & held_q;
    assign change     = |(pressed_d | released_d);

    // Repeat timer: a held-set change always wins over a coincident timer expiry.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        repeat_d = pressed_d;
        if (change) begin
            if (held_d != '0) begin
                state_d = ST_DELAY;
                cnt_d   = CW'(REPEAT_DELAY);
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                end
                ST_DELAY, ST_REPEAT: begin
                    if (tick) begin
                        if (cnt_q == CW'(1)) begin
                            repeat_d = held_q;
                            cnt_d    = CW'(REPEAT_RATE);
                            state_d  = ST_REPEAT;
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q       <= '0;
            ctype_q     <= CTYPE_NONE;
            connected_q <= 1'b0;
            held_q      <= '0;
            pressed_q   <= '0;
            released_q  <= '0;
            repeat_q    <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
        end else begin
            key_q       <= key_d;
            ctype_q     <= ctype_d;
            connected_q <= connected_d;
            held_q      <= held_d;
            pressed_q   <= pressed_d;
            released_q  <= released_d;
            repeat_q    <= repeat_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
        end
    end

    assign held       = held_q;
    assign pressed    = pressed_q;
    assign released   = released_q;
    assign repeat_out = repeat_q;
    assign connected  = connected_q;
    assign ctype      = ctype_q;

endmodule

// File: tb/tb_key_repeat_conditioner.sv
// Directed bench for key_repeat_conditioner with REPEAT_DELAY=3, REPEAT_RATE=2, DEBOUNCE_TICKS=2.
module tb_key_repeat_conditioner;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        tick   = 1'b0;
    logic [31:0] key_in = 32'h0;
    logic [15:0] held, pressed, released, repeat_out;
    logic        connected;
    logic [3:0]  ctype;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    key_repeat_conditioner #(
        .REPEAT_DELAY  (3),
        .REPEAT_RATE   (2),
        .DEBOUNCE_TICKS(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .key_in    (key_in),
        .held      (held),
        .pressed   (pressed),
        .released  (released),
        .repeat_out(repeat_out),
        .connected (connected),
        .ctype     (ctype)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // One clock with tick driven to t; returns #1 after the edge.
    task automatic cyc(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    // n tick periods of 4 cycles; repeat_out expected = val on ticks first, first+step, ...
    task automatic run_ticks(input string tag, input int n, input int first, input int step,
                             input logic [15:0] val);
        logic [15:0] exp;
        for (int k = 1; k <= n; k++) begin
            for (int c = 0; c < 3; c++) begin
                cyc(1'b0);
                chk(tag, repeat_out, 16'h0);
            end
            cyc(1'b1);
            exp = (first > 0 && k >= first && ((k - first) % step) == 0) ? val : 16'h0;
            chk(tag, repeat_out, exp);
        end
    endtask

    initial begin
        repeat (2) cyc(1'b0);
        chk("rst_held", held, 16'h0);
        chk("rst_pressed", pressed, 16'h0);
        chk("rst_released", released, 16'h0);
        chk("rst_repeat", repeat_out, 16'h0);
        chk("rst_connected", 16'(connected), 16'h0);
        chk("rst_ctype", 16'(ctype), 16'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0);
            chk("idle_quiet", pressed | released | repeat_out | held, 16'h0);
        end

`ifdef KEY_DEBOUNCE_EN
        // 1-tick glitch on dpad_left must not reach held
        key_in = 32'h1000_0004;
        cyc(1'b0);
        cyc(1'b1);
        chk("glitch_held0", held, 16'h0);
        key_in = 32'h1000_0000;
        cyc(1'b0);
        cyc(1'b0);
        run_ticks("glitch_rep", 3, 0, 1, 16'h0);
        chk("glitch_held", held, 16'h0);
        chk("glitch_pressed", pressed, 16'h0);
        // stable 2-tick press
        key_in = 32'h1000_0004;
        cyc(1'b0);
        cyc(1'b1);
        chk("db_tick1_held", held, 16'h0);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        chk("db_tick2_held", held, 16'h0004);
        chk("db_tick2_pressed", pressed, 16'h0004);
        chk("db_tick2_repeat", repeat_out, 16'h0004);
        // disconnect bypasses debounce
        key_in = 32'h0000_0004;
        cyc(1'b0);
        cyc(1'b0);
        chk("db_disc_held", held, 16'h0);
        chk("db_disc_released", released, 16'h0004);
`else
        // face_a press on builtin controller; bits [27:16] ignored
        key_in = 32'h1ABC_0010;
        cyc(1'b0);
        chk("c1_connected", 16'(connected), 16'h1);
        chk("c1_ctype", 16'(ctype), 16'h1);
        chk("c1_held", held, 16'h0);
        cyc(1'b0);
        chk("c2_held", held, 16'h0010);
        chk("c2_pressed", pressed, 16'h0010);
        chk("c2_released", released, 16'h0);
        chk("c2_repeat", repeat_out, 16'h0010);
        cyc(1'b0);
        chk("c3_pressed", pressed, 16'h0);
        chk("c3_repeat", repeat_out, 16'h0);
        chk("c3_held", held, 16'h0010);
        run_ticks("rep_a", 10, 3, 2, 16'h0010);

        // dpad_up added with tick expiry in the same cycle
        key_in = 32'h1000_0011;
        cyc(1'b0);
        cyc(1'b1);
        chk("coll_repeat", repeat_out, 16'h0001);
        chk("coll_pressed", pressed, 16'h0001);
        chk("coll_held", held, 16'h0011);
        run_ticks("rep_au", 3, 3, 2, 16'h0011);

        // controller disconnect
        key_in = 32'h0000_0011;
        cyc(1'b0);
        chk("disc_connected", 16'(connected), 16'h0);
        chk("disc_ctype", 16'(ctype), 16'h0);
        chk("disc_held_pre", held, 16'h0011);
        cyc(1'b0);
        chk("disc_held", held, 16'h0);
        chk("disc_released", released, 16'h0011);
        chk("disc_pressed", pressed, 16'h0);
        chk("disc_repeat", repeat_out, 16'h0);
        cyc(1'b0);
        chk("disc_released_1cyc", released, 16'h0);
        run_ticks("disc_quiet", 4, 0, 1, 16'h0);
`endif

        // reach REPEAT, then assert reset mid-cycle with a tick pending
        key_in = 32'h1000_0010;
        cyc(1'b0);
        cyc(1'b0);
        for (int k = 0; k < 7; k++) begin
            cyc(1'b0);
            cyc(1'b0);
            cyc(1'b0);
            cyc(1'b1);
        end
        chk("pre_rst_held", held, 16'h0010);
        tick = 1'b1;
        #2;
        reset  = 1'b1;
        key_in = 32'h0;
        #1;
        chk("async_held", held, 16'h0);
        chk("async_pressed", pressed, 16'h0);
        chk("async_released", released, 16'h0);
        chk("async_repeat", repeat_out, 16'h0);
        chk("async_connected", 16'(connected), 16'h0);
        chk("async_ctype", 16'(ctype), 16'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        tick  = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc((i % 4) == 3);
            chk("post_rst_quiet", pressed | released | repeat_out | held, 16'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
